// File: rtl/byte_seq_pkg.sv
// -----------------------------------------------------------------------------
// byte_seq_pkg
//
// Shared definitions for the byte-serial add sequencer:
//   BYTE_W     - width of one operand/sum byte.
//   state_e    - sequencer state: IDLE (waiting for the first byte of an
//                operation) or BUSY (inside an operation).
//   idx_width  - width of the byte index / byte counter, never less than 1
//                so that a single-byte build still has a legal vector.
// -----------------------------------------------------------------------------
package byte_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int idx_width(input int num_bytes);
        return (num_bytes > 1) ? $clog2(num_bytes) : 1;
    endfunction

endpackage : byte_seq_pkg

// File: rtl/simple_8bit_adder.sv
// -----------------------------------------------------------------------------
// simple_8bit_adder
//
// Purely combinational 8-bit adder with carry in and carry out.
//   a, b  in  8  addends
//   cin   in  1  carry in
//   sum   out 8  low 8 bits of a + b + cin
//   cout  out 1  bit 8 of a + b + cin
// -----------------------------------------------------------------------------
module simple_8bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] full_sum;

    // Zero-extend every term to 9 bits so the carry lands in bit 8.
    assign full_sum = {1'b0, a} + {1'b0, b} + {8'b0, cin};

    assign sum  = full_sum[7:0];
    assign cout = full_sum[8];

endmodule : simple_8bit_adder

// File: rtl/byte_serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// byte_serial_add_sequencer
//
// Adds two NUM_BYTES-wide operands delivered as a little-endian stream of
// byte pairs, one byte pair per cycle, using a single 8-bit adder and a
// registered inter-byte carry. Each accepted byte pair produces one sum byte
// on a registered output stream one cycle later. The last sum byte of an
// operation carries the final carry-out and an "entire sum is zero" flag.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   op_cin     in   1      carry-in of the operation (first beat only)
//   clr        in   1      synchronous abort of the in-flight operation
//   in_valid   in   1      byte pair presented
//   in_ready   out  1      byte pair can be accepted this cycle
//   in_a       in   8      operand A byte, LSB byte first
//   in_b       in   8      operand B byte, LSB byte first
//   out_valid  out  1      sum byte presented
//   out_ready  in   1      consumer takes the sum byte
//   out_sum    out  8      sum byte
//   out_idx    out  IDX_W  byte index of out_sum
//   out_last   out  1      out_sum is the final byte of the operation
//   out_cout   out  1      final carry-out (last beat only, else 0)
//   out_zero   out  1      all sum bytes were zero (last beat only, else 0)
// -----------------------------------------------------------------------------
module byte_serial_add_sequencer
    import byte_seq_pkg::*;
#(
    parameter  int NUM_BYTES = 4,
    localparam int IDX_W     = idx_width(NUM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_cin,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_zero
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,    state_d;
    logic [IDX_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic                carry_q,    carry_d;
    logic                zero_acc_q, zero_acc_d;

    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_sum_q,   out_sum_d;
    logic [IDX_W-1:0]    out_idx_q,   out_idx_d;
    logic                out_last_q,  out_last_d;
    logic                out_cout_q,  out_cout_d;
    logic                out_zero_q,  out_zero_d;

    // -------------------------------------------------------------------------
    // Handshake and datapath
    // -------------------------------------------------------------------------
    logic              accept;
    logic              is_last;
    logic              add_cin;
    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;
    logic              zero_now;

    // The output register can take a new byte when it is empty or being
    // drained in this same cycle; clr blocks acceptance outright.
    assign in_ready = !clr && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_last  = (byte_cnt_q == LAST_IDX);

    // The first byte of an operation takes the caller's carry-in; every later
    // byte chains the carry captured from the previous byte.
    assign add_cin  = (state_q == IDLE) ? op_cin : carry_q;

    simple_8bit_adder u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Running "every byte so far was zero" including the current byte.
    assign zero_now = (add_sum == '0) && ((state_q == IDLE) || zero_acc_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets its hold value first, so no
        // path through the block can leave one unassigned and infer a latch.
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        carry_d     = carry_q;
        zero_acc_d  = zero_acc_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_zero_d  = out_zero_q;

        if (clr) begin
            // Abort: forget the operation and drop any pending output byte.
            state_d     = IDLE;
            byte_cnt_d  = '0;
            carry_d     = 1'b0;
            zero_acc_d  = 1'b1;
            out_valid_d = 1'b0;
        end else if (accept) begin
            carry_d    = add_cout;
            zero_acc_d = zero_now;

            if (is_last) begin
                state_d    = IDLE;
                byte_cnt_d = '0;
            end else begin
                state_d    = BUSY;
                byte_cnt_d = byte_cnt_q + IDX_W'(1);
            end

            out_valid_d = 1'b1;
            out_sum_d   = add_sum;
            out_idx_d   = byte_cnt_q;
            out_last_d  = is_last;
            out_cout_d  = is_last && add_cout;
            out_zero_d  = is_last && zero_now;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every flop sampling the values from
    // before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            carry_q     <= 1'b0;
            zero_acc_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            carry_q     <= carry_d;
            zero_acc_q  <= zero_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_zero  = out_zero_q;

endmodule : byte_serial_add_sequencer

// File: tb/tb_byte_serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_add_sequencer
//
// Drives a 4-byte build and a 1-byte build of the sequencer. Expected sum
// bytes come from whole-operand arithmetic (A + B + cin as one wide number),
// then sliced into bytes.
// -----------------------------------------------------------------------------
module tb_byte_serial_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 4-byte build
    logic       op_cin, clr, in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic       out_valid, out_ready, out_last, out_cout, out_zero;
    logic [7:0] out_sum;
    logic [1:0] out_idx;

    // 1-byte build
    logic       s1_op_cin, s1_clr, s1_in_valid, s1_in_ready;
    logic [7:0] s1_in_a, s1_in_b;
    logic       s1_out_valid, s1_out_ready, s1_out_last, s1_out_cout, s1_out_zero;
    logic [7:0] s1_out_sum;
    logic [0:0] s1_out_idx;

    int n_checks = 0;
    int n_fail   = 0;

    byte_serial_add_sequencer #(.NUM_BYTES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .op_cin    (op_cin),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_zero  (out_zero)
    );

    byte_serial_add_sequencer #(.NUM_BYTES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .op_cin    (s1_op_cin),
        .clr       (s1_clr),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_a      (s1_in_a),
        .in_b      (s1_in_b),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_sum   (s1_out_sum),
        .out_idx   (s1_out_idx),
        .out_last  (s1_out_last),
        .out_cout  (s1_out_cout),
        .out_zero  (s1_out_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-operand reference: 33-bit result of A + B + cin.
    function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + {32'b0, cin};
    endfunction

    // Present one byte pair to the 4-byte build, expect it to be taken, then
    // check the registered output one cycle later. Called just after posedge.
    task automatic beat4(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] e_sum, input int e_idx,
                         input logic e_last, input logic e_cout, input logic e_zero);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        op_cin   = cin;
        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".sum"},   out_sum,   e_sum);
        check({tag, ".idx"},   out_idx,   e_idx);
        check({tag, ".last"},  out_last,  e_last);
        check({tag, ".cout"},  out_cout,  e_cout);
        check({tag, ".zero"},  out_zero,  e_zero);
    endtask

    // Full 4-byte operation with out_ready held high. op_cin is randomised
    // on the later beats, where it must be ignored.
    task automatic run_op4(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
        logic [32:0] s;
        s = ref_sum(a, b, cin);
        for (int i = 0; i < 4; i++) begin
            beat4($sformatf("%s.b%0d", tag, i), a[8*i +: 8], b[8*i +: 8],
                  (i == 0) ? cin : 1'($urandom_range(0, 1)),
                  s[8*i +: 8], i, i == 3,
                  (i == 3) && s[32], (i == 3) && (s[31:0] == 32'd0));
        end
        in_valid = 1'b0;
    endtask

    task automatic beat1(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        s1_in_valid = 1'b1;
        s1_in_a     = a;
        s1_in_b     = b;
        s1_op_cin   = cin;
        @(negedge clk);
        check({tag, ".in_ready"}, s1_in_ready, 1);
        @(posedge clk); #1;
        check({tag, ".valid"}, s1_out_valid, 1);
        check({tag, ".sum"},   s1_out_sum,   s[7:0]);
        check({tag, ".idx"},   s1_out_idx,   0);
        check({tag, ".last"},  s1_out_last,  1);
        check({tag, ".cout"},  s1_out_cout,  s[8]);
        check({tag, ".zero"},  s1_out_zero,  s[7:0] == 8'd0);
    endtask

    initial begin
        logic [32:0] s;
        logic [31:0] ra, rb;

        rst = 1'b1;
        op_cin = 0; clr = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 1;
        s1_op_cin = 0; s1_clr = 0; s1_in_valid = 0; s1_in_a = 0; s1_in_b = 0; s1_out_ready = 1;

        // ---- Reset state ----
        #12;
        check("rst.valid", out_valid, 0);
        check("rst.sum",   out_sum,   0);
        check("rst.idx",   out_idx,   0);
        check("rst.last",  out_last,  0);
        check("rst.cout",  out_cout,  0);
        check("rst.zero",  out_zero,  0);
        check("rst.s1_valid", s1_out_valid, 0);
        #11 rst = 1'b0;
        @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        @(posedge clk); #1;

        // ---- Carry propagation ----
        run_op4("carry", 32'h0000_00FF, 32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        check("carry.drain_valid", out_valid, 0);

        // ---- Full wrap ----
        run_op4("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

        // ---- Backpressure on byte 1 ----
        s = ref_sum(32'h1234_5678, 32'h1111_1111, 1'b0);
        check("bp.model", s, 33'h0_2345_6789);
        beat4("bp.b0", 8'h78, 8'h11, 1'b0, s[7:0],   0, 0, 0, 0);
        beat4("bp.b1", 8'h56, 8'h11, 1'b1, s[15:8],  1, 0, 0, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h34;
        in_b      = 8'h11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp.stall%0d.in_ready", c), in_ready, 0);
            check($sformatf("bp.stall%0d.valid", c),    out_valid, 1);
            check($sformatf("bp.stall%0d.sum", c),      out_sum, s[15:8]);
            check($sformatf("bp.stall%0d.idx", c),      out_idx, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        beat4("bp.b2", 8'h34, 8'h11, 1'b1, s[23:16], 2, 0, 0, 0);
        beat4("bp.b3", 8'h12, 8'h11, 1'b0, s[31:24], 3, 1, s[32], 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp.drain_valid", out_valid, 0);

        // ---- Abort after two beats, then a fresh operation ----
        beat4("abort.b0", 8'hFF, 8'hFF, 1'b0, 8'hFE, 0, 0, 0, 0);
        beat4("abort.b1", 8'hFF, 8'hFF, 1'b0, 8'hFF, 1, 0, 0, 0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_a     = 8'h01;
        in_b     = 8'h02;
        @(negedge clk);
        check("abort.in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("abort.valid", out_valid, 0);
        clr      = 1'b0;
        in_valid = 1'b0;
        run_op4("after_abort", 32'h0000_0001, 32'h0000_0001, 1'b0);

        // ---- Reset mid-operation ----
        beat4("mrst.b0", 8'h33, 8'h44, 1'b0, 8'h77, 0, 0, 0, 0);
        beat4("mrst.b1", 8'h22, 8'h55, 1'b0, 8'h77, 1, 0, 0, 0);
        in_valid = 1'b1;
        in_a     = 8'h11;
        in_b     = 8'h66;
        #1 rst = 1'b1;
        #1;
        check("mrst.valid", out_valid, 0);
        check("mrst.sum",   out_sum,   0);
        check("mrst.idx",   out_idx,   0);
        check("mrst.last",  out_last,  0);
        check("mrst.cout",  out_cout,  0);
        check("mrst.zero",  out_zero,  0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst.in_ready", in_ready, 1);
        @(posedge clk); #1;
        run_op4("after_rst", 32'h8000_00FF, 32'h8000_0000, 1'b1);

        // ---- Back-to-back, op_cin 1 then 0 ----
        rb = $urandom();
        run_op4("b2b.op0", 32'hFFFF_FFFF, rb, 1'b1);
        run_op4("b2b.op1", 32'h0000_0000, 32'h0000_0000, 1'b0);

        // ---- Randomised back-to-back operations ----
        for (int n = 0; n < 8; n++) begin
            ra = $urandom();
            rb = $urandom();
            if (n == 2) rb = ~ra;
            run_op4($sformatf("rand%0d", n), ra, rb, 1'($urandom_range(0, 1)));
        end

        // ---- Single-byte build ----
        beat1("s1.wrap",  8'hFF, 8'h00, 1'b1);
        beat1("s1.nocin", 8'h00, 8'h00, 1'b0);
        beat1("s1.ovf",   8'h80, 8'h80, 1'b0);
        for (int n = 0; n < 6; n++) begin
            beat1($sformatf("s1.rand%0d", n), 8'($urandom()), 8'($urandom()),
                  1'($urandom_range(0, 1)));
        end
        s1_in_valid = 1'b0;
        @(posedge clk); #1;
        check("s1.drain_valid", s1_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_byte_serial_add_sequencer

// File: doc/byte_serial_add_sequencer.md
# byte_serial_add_sequencer

Sequential front/back end for the `simple_8bit_adder` datapath. It accepts two NUM_BYTES-wide operands as a little-endian byte stream over a valid/ready handshake. Each accepted byte pair is fed through the 8-bit adder with a registered inter-byte carry, so multi-byte sums are computed at one byte per cycle. Sum bytes are emitted on a registered valid/ready output stream, with final carry and zero flags attached to the last beat.

## Interface
- NUM_BYTES, 4: bytes per operand; legal range 1–16.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_cin  in  1  carry-in for the operation; sampled only on the first beat.
- clr  in  1  synchronous abort; discards the in-flight operation.
- in_valid  in  1  a byte pair is presented.
- in_ready  out  1  the block can accept a byte pair this cycle.
- in_a  in  8  operand A byte, LSB byte first.
- in_b  in  8  operand B byte, LSB byte first.
- out_valid  out  1  a sum byte is presented.
- out_ready  in  1  the consumer accepts the sum byte.
- out_sum  out  8  sum byte.
- out_idx  out  $clog2(NUM_BYTES) (min 1)  byte index of out_sum.
- out_last  out  1  out_sum is byte NUM_BYTES-1.
- out_cout  out  1  final carry-out; meaningful only when out_last=1, else 0.
- out_zero  out  1  all NUM_BYTES sum bytes were 0x00; meaningful only when out_last=1, else 0.

## Operation
- A beat is accepted when in_valid && in_ready.
- in_ready = !clr && (!out_valid || out_ready). Single output register with flow-through; no skid buffer.
- **State IDLE** (byte_cnt=0): an accepted beat uses cin = op_cin, sets zero_acc = (sum==0), and goes to BUSY. If NUM_BYTES=1, it is also the last beat and the state stays IDLE.
- **State BUSY**: an accepted beat uses cin = carry_q and updates zero_acc &= (sum==0).
  - byte_cnt increments on every accepted beat.
  - On the beat with byte_cnt = NUM_BYTES-1, byte_cnt wraps to 0 and the state returns to IDLE.
- carry_q captures the adder cout on every accepted beat.
- Output register loads on every accepted beat:
  - out_sum and out_idx = byte_cnt.
  - out_last, out_cout = adder cout, and out_zero = final zero_acc (last beat only).
- Output hold: out_valid && !out_ready holds every out_* field stable, and in_ready is 0.
- Output advance: out_valid && out_ready with no new accept clears out_valid.
- Arithmetic: each beat computes {cout,sum} = in_a + in_b + cin as a 9-bit result. There is no signed or overflow interpretation.
- **clr**:
  - next cycle: state=IDLE, byte_cnt=0, carry_q=0, zero_acc=1, out_valid=0.
  - clr overrides a same-cycle in_valid; no beat is accepted.
  - clr overrides a pending output; the byte is dropped.
- Back-to-back operations: the first beat of operation N+1 may be accepted in the cycle immediately after the last beat of operation N. op_cin for operation N+1 is sampled on that beat.
- **Reset** (asynchronous, any time including mid-operation):
  - out_valid=0, out_sum=0, out_idx=0, out_last=0, out_cout=0, out_zero=0.
  - state=IDLE, byte_cnt=0, carry_q=0, zero_acc=1.
  - in_ready=1 once rst deasserts (provided clr=0).

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 byte/cycle with out_ready held high. A full operation completes NUM_BYTES cycles after its first accept.
- The carry path is adder cout -> carry_q -> adder cin. The combinational depth is one 8-bit ripple chain plus muxing per cycle.
- in_ready depends combinationally on out_ready and clr. All out_* signals are driven directly from flops.

## Structure
- Package byte_seq_pkg holds:
  - BYTE_W = 8.
  - the state enum {IDLE, BUSY}.
  - the idx width function max(1, $clog2(NUM_BYTES)).
- One sub-module: instantiate the existing simple_8bit_adder combinationally (a=in_a, b=in_b, cin=muxed carry).
- All sequencing lives in this block: FSM, counter, carry/zero registers and output register.

## Test plan
- **Carry propagation.** NUM_BYTES=4, A=0x000000FF, B=0x00000001, op_cin=0, out_ready=1. Required:
  - sum bytes 00, 01, 00, 00 with out_idx 0..3.
  - out_last only on idx 3; out_cout=0; out_zero=0.
  - each byte appears 1 cycle after its accept.
- **Full wrap.** A=0xFFFFFFFF, B=0x00000000, op_cin=1. Required: all sum bytes 00, out_cout=1 and out_zero=1 on the last beat.
- **Backpressure.** out_ready=0 for 3 cycles while byte 1 is presented. Required:
  - in_ready=0 during the stall.
  - out_sum and out_idx stable.
  - no beat lost or duplicated.
  - final result matches 0x12345678 + 0x11111111 = 0x23456789, cout=0.
- **Abort.** clr after 2 of 4 beats, then a fresh operation 0x00000001 + 0x00000001, op_cin=0. Required:
  - out_valid drops the cycle after clr.
  - the new result is 02, 00, 00, 00 (no stale carry_q).
- **Reset mid-operation.** Assert rst asynchronously between clock edges during beat 2. Required:
  - all outputs go to 0 immediately.
  - after release, the next beat is treated as idx 0 with op_cin.
- **Back-to-back with differing op_cin; NUM_BYTES=1 build.** Two operations with no idle cycle (op_cin 1 then 0). Required:
  - the second operation's first byte ignores the first operation's carry.
  - in the NUM_BYTES=1 build, every beat has out_last=1.
